debounced_logic_unit: RTL and testbench
=======================================

Name: debounced_logic_unit

Overview:
- Parametrised successor to the board's combinational gate demo.
- Takes two WIDTH-bit operand vectors from MKR header pins, synchronises and debounces every bit, then applies a runtime-selectable bitwise logic function.
- Drives a registered result vector back to header pins, plus a one-cycle change strobe and a change-event counter for LED/debug use.

Parameters:
- WIDTH, 2, bits per operand vector (1..16).
- DEBOUNCE_CYCLES, 48000, cycles an input must be stable before acceptance (1 ms at 48 MHz); must be >= 1.
- CNT_W, 16, width of per-bit debounce counters; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- EVT_W, 8, width of the change-event counter.

Ports:
- iCLK, input, 1, system clock (48 MHz board clock).
- iRESETn, input, 1, asynchronous active-low reset.
- iA, input, WIDTH, operand A; raw asynchronous pin inputs.
- iB, input, WIDTH, operand B; raw asynchronous pin inputs.
- iMODE, input, 3, function select; synchronous to iCLK.
- oY, output, WIDTH, registered result.
- oCHANGED, output, 1, one-cycle pulse when oY changes value.
- oCOUNT, output, EVT_W, number of oY changes since reset; wraps.

Behaviour:
- Reset (iRESETn low, asynchronous): all synchroniser flops, debounced state, debounce counters, oY, oCHANGED and oCOUNT clear to 0. Reset mid-debounce discards the partial count.
- Synchroniser: two-flop chain per bit of iA and iB. The sync value is the second flop.
- Debouncer, per bit, with a stable register and a counter:
  - sync == stable: counter <= 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise: counter increments.
  - Any pulse lasting fewer than DEBOUNCE_CYCLES cycles at the sync output is rejected.
  - DEBOUNCE_CYCLES=1: stable follows sync one cycle later.
- Latency: a clean pin edge reaches the stable register 2+DEBOUNCE_CYCLES cycles later; oY updates 1 cycle after that.
- Function, applied bitwise on the debounced dA/dB; iMODE sampled each cycle:
  - 0: ~dA
  - 1: ~dB
  - 2: dA & dB
  - 3: dA | dB
  - 4: dA ^ dB
  - 5: ~(dA & dB)
  - 6: ~(dA | dB)
  - 7: ~(dA ^ dB)
- oY <= f(dA, dB, iMODE) every cycle. A mode change is reflected on oY the next cycle and is not debounced.
- Change detect: oCHANGED = 1 for exactly the cycle after oY is loaded with a value different from its previous value; otherwise 0.
- Event counter: oCOUNT increments by 1 on each oCHANGED pulse; wraps from 2^EVT_W-1 to 0.
- Simultaneous events:
  - Operand and mode change in the same cycle produce one evaluation. At most one oCHANGED per cycle, regardless of how many bits flip.
  - A mode change that leaves oY unchanged (e.g. AND to OR with dA == dB) produces no pulse.
- First cycle after reset release: oY evaluates f(0, 0, iMODE). If non-zero (modes 0, 1, 5, 6, 7), oCHANGED pulses and oCOUNT becomes 1. This is intended behaviour.
- No combinational path from iA, iB or iMODE to any output.

Test Plan (WIDTH=2, DEBOUNCE_CYCLES=4, EVT_W=8):
- Reset: hold iRESETn low with iMODE=2, then release -> oY=00, oCHANGED never pulses, oCOUNT=0. Same with iMODE=0 -> oY=11 one cycle after release, single oCHANGED pulse, oCOUNT=1.
- Debounce latency: iMODE=3, iA 00->01 held -> oY=01 exactly 7 cycles after the edge (2 sync + 4 debounce + 1), one oCHANGED pulse, oCOUNT=1.
- Glitch rejection: iA bit0 high for 3 cycles at the sync output, then low -> oY, oCHANGED and oCOUNT unchanged. Same pulse for 4 cycles -> accepted.
- Mode sweep: debounced dA=01, dB=11, iMODE stepped 0..7 one per cycle -> oY sequence 10, 00, 01, 11, 10, 10, 00, 01. oCHANGED pulses only where the value differs from the previous one.
- Counter wrap: toggle iA bit0 (mode 3, debounced each time) 256 times -> oCOUNT returns to 0 with no glitch on oY.
- Reset mid-debounce: iA edge, assert iRESETn after 2 counter cycles, release with iA still high -> all outputs 0 immediately on assertion. After release, full 2+4+1 latency elapses before oY=01.

Source files
------------

// File: rtl/debounced_logic_unit.sv
// ---------------------------------------------------------------------------
// debounced_logic_unit
//
// Takes two WIDTH-bit operand vectors straight from header pins, runs every
// bit through a two-flop synchroniser and a counter-based debouncer, then
// applies a runtime-selectable bitwise logic function to the debounced
// operands. The result is registered and drives header pins, alongside a
// one-cycle change strobe and a wrapping change-event counter.
//
// Ports:
//   iCLK      - system clock (48 MHz board clock)
//   iRESETn   - asynchronous active-low reset
//   iA, iB    - raw asynchronous operand pins, WIDTH bits each
//   iMODE     - function select, synchronous to iCLK
//                 0 ~A   1 ~B   2 A&B   3 A|B
//                 4 A^B  5 NAND 6 NOR   7 XNOR
//   oY        - registered result, WIDTH bits
//   oCHANGED  - one-cycle pulse in the cycle oY holds a new value
//   oCOUNT    - number of oY changes since reset, EVT_W bits, wraps
// ---------------------------------------------------------------------------
module debounced_logic_unit #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int CNT_W           = 16,
    parameter int EVT_W           = 8
) (
    input  logic             iCLK,
    input  logic             iRESETn,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [2:0]       iMODE,
    output logic [WIDTH-1:0] oY,
    output logic             oCHANGED,
    output logic [EVT_W-1:0] oCOUNT
);

    // Both operands share one bank of synchronisers and debouncers:
    // bits [WIDTH-1:0] carry A, bits [2*WIDTH-1:WIDTH] carry B.
    localparam int NBITS = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] raw_bits;
    logic [NBITS-1:0] sync_meta;
    logic [NBITS-1:0] sync_bits;
    logic [NBITS-1:0] stable_bits;
    logic [CNT_W-1:0] db_cnt [NBITS];

    logic [WIDTH-1:0] deb_a;
    logic [WIDTH-1:0] deb_b;
    logic [WIDTH-1:0] y_next;

    assign raw_bits = {iB, iA};
    assign deb_a    = stable_bits[WIDTH-1:0];
    assign deb_b    = stable_bits[NBITS-1:WIDTH];

    // Two-flop synchroniser per pin. The second flop is the only one the
    // rest of the design looks at; the first may go metastable.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            sync_meta <= '0;
            sync_bits <= '0;
        end else begin
            sync_meta <= raw_bits;
            sync_bits <= sync_meta;
        end
    end

    // Per-bit debouncer. The counter only runs while the synchronised value
    // disagrees with the accepted one; any agreement clears it, so a level
    // is accepted only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples. Acceptance happens on the sample where the counter already
    // sits at DEBOUNCE_CYCLES-1, which also makes DEBOUNCE_CYCLES=1 a plain
    // one-cycle follower.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            stable_bits <= '0;
            for (int i = 0; i < NBITS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (sync_bits[i] == stable_bits[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    stable_bits[i] <= sync_bits[i];
                    db_cnt[i]      <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Bitwise function of the debounced operands. The mode input is used
    // directly since it is already synchronous and is intentionally not
    // debounced.
    always_comb begin
        y_next = '0;
        case (iMODE)
            3'd0:    y_next = ~deb_a;
            3'd1:    y_next = ~deb_b;
            3'd2:    y_next = deb_a & deb_b;
            3'd3:    y_next = deb_a | deb_b;
            3'd4:    y_next = deb_a ^ deb_b;
            3'd5:    y_next = ~(deb_a & deb_b);
            3'd6:    y_next = ~(deb_a | deb_b);
            3'd7:    y_next = ~(deb_a ^ deb_b);
            default: y_next = '0;
        endcase
    end

    // Output register with change detection. Comparing the new value against
    // the current oY yields a single strobe however many bits flip, and the
    // event counter advances on the same edge so it always equals the number
    // of strobes seen so far.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oY       <= '0;
            oCHANGED <= 1'b0;
            oCOUNT   <= '0;
        end else begin
            oY       <= y_next;
            oCHANGED <= (y_next != oY);
            if (y_next != oY) begin
                oCOUNT <= oCOUNT + EVT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_debounced_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_debounced_logic_unit
//
// Scoreboard bench for debounced_logic_unit with WIDTH=2, DEBOUNCE_CYCLES=4.
// A behavioural model advances once per clock; its predicted oY/oCHANGED is
// pushed to a queue at the edge and popped/compared just after it. Fixed
// constants cover reset values, latency, glitch rejection and the mode sweep.
// ---------------------------------------------------------------------------
module tb_debounced_logic_unit;

    localparam int WIDTH = 2;
    localparam int DC    = 4;
    localparam int CNT_W = 16;
    localparam int EVT_W = 8;

    logic             iCLK = 1'b0;
    logic             iRESETn;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic [2:0]       iMODE;
    logic [WIDTH-1:0] oY;
    logic             oCHANGED;
    logic [EVT_W-1:0] oCOUNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             ch;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural model state
    logic [WIDTH-1:0] m_s1a, m_s2a, m_s1b, m_s2b;
    logic [WIDTH-1:0] m_da, m_db, m_y;
    logic             m_ch;
    logic [EVT_W-1:0] m_cnt;
    int               m_run_a [WIDTH];
    int               m_run_b [WIDTH];

    debounced_logic_unit #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CNT_W),
        .EVT_W(EVT_W)
    ) dut (
        .iCLK(iCLK),
        .iRESETn(iRESETn),
        .iA(iA),
        .iB(iB),
        .iMODE(iMODE),
        .oY(oY),
        .oCHANGED(oCHANGED),
        .oCOUNT(oCOUNT)
    );

    // 100 MHz-ish bench clock; the period value is arbitrary
    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] refFunc(input logic [2:0] mode,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (mode)
            3'd0: return ~a;
            3'd1: return ~b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a & b);
            3'd6: return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic modelReset();
        m_s1a = '0; m_s2a = '0; m_s1b = '0; m_s2b = '0;
        m_da  = '0; m_db  = '0; m_y   = '0;
        m_ch  = 1'b0;
        m_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m_run_a[i] = 0;
            m_run_b[i] = 0;
        end
    endtask

    // One clock edge of the model: a level is accepted once the synchronised
    // pin has disagreed with the accepted level for DC consecutive samples.
    task automatic modelStep();
        logic [WIDTH-1:0] ny;
        ny    = refFunc(iMODE, m_da, m_db);
        m_ch  = (ny != m_y);
        if (m_ch) m_cnt = m_cnt + 1'b1;
        m_y   = ny;
        for (int i = 0; i < WIDTH; i++) begin
            if (m_s2a[i] != m_da[i]) begin
                m_run_a[i]++;
                if (m_run_a[i] == DC) begin
                    m_da[i]    = m_s2a[i];
                    m_run_a[i] = 0;
                end
            end else begin
                m_run_a[i] = 0;
            end
            if (m_s2b[i] != m_db[i]) begin
                m_run_b[i]++;
                if (m_run_b[i] == DC) begin
                    m_db[i]    = m_s2b[i];
                    m_run_b[i] = 0;
                end
            end else begin
                m_run_b[i] = 0;
            end
        end
        m_s2a = m_s1a; m_s1a = iA;
        m_s2b = m_s1b; m_s1b = iB;
    endtask

    // Advance one clock: predict at the edge, compare 1 time unit later,
    // then return on the falling edge where new stimulus may be driven.
    task automatic tick();
        exp_t e;
        @(posedge iCLK);
        modelStep();
        sb_q.push_back('{y: m_y, ch: m_ch});
        #1;
        e = sb_q.pop_front();
        checkOutput("oY", 32'(oY), 32'(e.y));
        checkOutput("oCHANGED", 32'(oCHANGED), 32'(e.ch));
        @(negedge iCLK);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] mode);
        iA    = a;
        iB    = b;
        iMODE = mode;
    endtask

    // Asserted on a falling edge; outputs must clear without waiting for a
    // clock. Pins are left as the caller set them.
    task automatic applyReset(input logic [2:0] mode);
        iMODE   = mode;
        iRESETn = 1'b0;
        #1;
        checkOutput("rst_oY", 32'(oY), 32'd0);
        checkOutput("rst_oCHANGED", 32'(oCHANGED), 32'd0);
        checkOutput("rst_oCOUNT", 32'(oCOUNT), 32'd0);
        modelReset();
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        iRESETn = 1'b1;
    endtask

    initial begin : stimulus
        logic [WIDTH-1:0] sweep_exp [8];
        logic [EVT_W-1:0] cnt_before;

        sweep_exp[0] = 2'b10; sweep_exp[1] = 2'b00;
        sweep_exp[2] = 2'b01; sweep_exp[3] = 2'b11;
        sweep_exp[4] = 2'b10; sweep_exp[5] = 2'b10;
        sweep_exp[6] = 2'b00; sweep_exp[7] = 2'b01;

        iRESETn = 1'b0;
        applyStimulus(2'b00, 2'b00, 3'd2);
        modelReset();
        @(negedge iCLK);

        // Reset with AND mode: f(0,0)=0, nothing changes
        applyReset(3'd2);
        ticks(3);
        checkOutput("rst_and_y", 32'(oY), 32'd0);
        checkOutput("rst_and_cnt", 32'(oCOUNT), 32'd0);

        // Reset with NOT-A mode: oY=11 one cycle after release, single pulse
        applyReset(3'd0);
        tick();
        checkOutput("rst_nota_y", 32'(oY), 32'b11);
        tick();
        checkOutput("rst_nota_cnt", 32'(oCOUNT), 32'd1);
        ticks(2);

        // Debounce latency, OR mode: oY=01 exactly 7 cycles after the edge
        applyReset(3'd3);
        ticks(2);
        applyStimulus(2'b01, 2'b00, 3'd3);
        ticks(6);
        checkOutput("lat_pre_y", 32'(oY), 32'd0);
        tick();
        checkOutput("lat_y", 32'(oY), 32'b01);
        checkOutput("lat_ch", 32'(oCHANGED), 32'd1);
        ticks(2);
        checkOutput("lat_cnt", 32'(oCOUNT), 32'd1);

        // Glitch rejection: return A to 00 first, then a 3-cycle pulse
        applyStimulus(2'b00, 2'b00, 3'd3);
        ticks(10);
        cnt_before = oCOUNT;
        checkOutput("glitch_base_cnt", 32'(cnt_before), 32'(m_cnt));
        applyStimulus(2'b01, 2'b00, 3'd3);
        ticks(3);
        applyStimulus(2'b00, 2'b00, 3'd3);
        ticks(12);
        checkOutput("glitch3_y", 32'(oY), 32'd0);
        checkOutput("glitch3_cnt", 32'(oCOUNT), 32'(cnt_before));

        // A 4-cycle pulse is accepted, then the low level is accepted again
        applyStimulus(2'b01, 2'b00, 3'd3);
        ticks(4);
        applyStimulus(2'b00, 2'b00, 3'd3);
        ticks(3);
        checkOutput("glitch4_y", 32'(oY), 32'b01);
        ticks(10);
        checkOutput("glitch4_cnt", 32'(oCOUNT), 32'(cnt_before + 8'd2));

        // Mode sweep with dA=01, dB=11
        applyStimulus(2'b01, 2'b11, 3'd3);
        ticks(10);
        for (int m = 0; m < 8; m++) begin
            iMODE = 3'(m);
            tick();
            checkOutput($sformatf("sweep_m%0d", m), 32'(oY), 32'(sweep_exp[m]));
        end
        ticks(2);
        checkOutput("sweep_cnt", 32'(oCOUNT), 32'(m_cnt));

        // Reset in the middle of a debounce: A settled at 00, then an edge
        applyStimulus(2'b00, 2'b00, 3'd3);
        ticks(10);
        applyStimulus(2'b01, 2'b00, 3'd3);
        ticks(4);
        applyReset(3'd3);
        ticks(6);
        checkOutput("midrst_pre_y", 32'(oY), 32'd0);
        tick();
        checkOutput("midrst_y", 32'(oY), 32'b01);
        ticks(2);
        checkOutput("midrst_cnt", 32'(oCOUNT), 32'd1);

        // Counter wrap: 256 debounced toggles of A bit0 in OR mode
        applyStimulus(2'b00, 2'b00, 3'd3);
        applyReset(3'd3);
        ticks(2);
        for (int k = 0; k < 256; k++) begin
            iA[0] = ~iA[0];
            ticks(8);
            checkOutput("wrap_cnt", 32'(oCOUNT), 32'(m_cnt));
        end
        checkOutput("wrap_zero", 32'(oCOUNT), 32'd0);
        checkOutput("wrap_y", 32'(oY), 32'd0);

        if (sb_q.size() != 0) begin
            checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
